// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, one-entry hold buffer for decode stalls, IF/ID register.
// Define FETCH_PERF_EN to add the fetch_cnt/bubble_cnt performance counters.
module fetch_stage #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             stall_d,
  output logic [WIDTH-1:0] instr_d,
  output logic [WIDTH-1:0] pc_d,
  output logic [WIDTH-1:0] pc_plus4_d,
  output logic             valid_d,
  output logic [1:0]       immsrc_d
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      fetch_cnt,
  output logic [31:0]      bubble_cnt
`endif
);

  localparam logic [WIDTH-1:0] Nop       = WIDTH'(32'h0000_0013);
  localparam logic [WIDTH-1:0] Step      = WIDTH'(4);
  localparam logic [WIDTH-1:0] AlignMask = {{(WIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {StBoot, StFetch, StHold} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] hold_instr_q, hold_instr_d;
  logic [WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic             hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] id_instr_q, id_instr_d;
  logic [WIDTH-1:0] id_pc_q, id_pc_d;
  logic [WIDTH-1:0] id_pc4_q, id_pc4_d;
  logic             id_valid_q, id_valid_d;
  logic             load_word, load_bubble;
  logic [WIDTH-1:0] redirect_tgt;

  assign redirect_tgt = redirect_pc & AlignMask;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    hold_valid_d = hold_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    id_pc4_d     = id_pc4_q;
    id_valid_d   = id_valid_q;
    imem_req     = 1'b0;
    load_word    = 1'b0;
    load_bubble  = 1'b0;

    unique case (state_q)
      StBoot: begin
        // A redirect here only retargets the first fetch; IF/ID is already a bubble.
        if (redirect) fetch_pc_d = redirect_tgt;
        state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (redirect) begin
          fetch_pc_d  = redirect_tgt;
          load_bubble = 1'b1;
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + Step;
          if (stall_d) begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = fetch_pc_q;
            hold_valid_d = 1'b1;
            state_d      = StHold;
          end else begin
            load_word  = 1'b1;
            id_instr_d = imem_rdata;
            id_pc_d    = fetch_pc_q;
            id_pc4_d   = fetch_pc_q + Step;
          end
        end else if (!stall_d) begin
          load_bubble = 1'b1;
        end
      end
      StHold: begin
        if (redirect) begin
          fetch_pc_d   = redirect_tgt;
          hold_valid_d = 1'b0;
          load_bubble  = 1'b1;
          state_d      = StFetch;
        end else if (!stall_d) begin
          if (hold_valid_q) begin
            load_word  = 1'b1;
            id_instr_d = hold_instr_q;
            id_pc_d    = hold_pc_q;
            id_pc4_d   = hold_pc_q + Step;
          end
          hold_valid_d = 1'b0;
          state_d      = StFetch;
        end
      end
      default: state_d = StBoot;
    endcase

    if (load_word) id_valid_d = 1'b1;
    // Bubbles keep the previous pc_d/pc_plus4_d; only the instruction and valid change.
    if (load_bubble) begin
      id_instr_d = Nop;
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StBoot;
      fetch_pc_q   <= RESET_PC & AlignMask;
      hold_instr_q <= Nop;
      hold_pc_q    <= '0;
      hold_valid_q <= 1'b0;
      id_instr_q   <= Nop;
      id_pc_q      <= '0;
      id_pc4_q     <= '0;
      id_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_valid_q <= hold_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      id_pc4_q     <= id_pc4_d;
      id_valid_q   <= id_valid_d;
    end
  end

  assign imem_addr  = fetch_pc_q;
  assign instr_d    = id_instr_q;
  assign pc_d       = id_pc_q;
  assign pc_plus4_d = id_pc4_q;
  assign valid_d    = id_valid_q;

  always_comb begin
    immsrc_d = 2'b00;
    unique case (id_instr_q[6:0])
      7'b0100011: immsrc_d = 2'b01;
      7'b1100011: immsrc_d = 2'b10;
      7'b1101111: immsrc_d = 2'b11;
      default:    immsrc_d = 2'b00;
    endcase
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (load_word)   fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (load_bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = load_word ^ load_bubble;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized ack/stall/redirect/reset
// traffic against a transaction-level reference model.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall_d;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d;
  logic [1:0]  immsrc_d;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // Reference model: fetch mode 0=boot 1=fetch 2=hold
  int          m_mode;
  logic [31:0] m_pc, m_hword, m_hpc;
  logic [31:0] m_instr, m_pc_d, m_pc4;
  logic        m_valid;
  logic [31:0] m_fcnt, m_bcnt;

  fetch_stage #(
    .WIDTH    (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall_d     (stall_d),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d),
    .immsrc_d    (immsrc_d)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .bubble_cnt  (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    logic [6:0] opc;
    case (a)
      32'h0000_0300: return 32'h0011_2023;
      32'h0000_0304: return 32'hFE00_0EE3;
      32'h0000_0308: return 32'h0000_006F;
      32'h0000_030C: return 32'h0000_0013;
      default: begin
        case (a[3:2])
          2'd0:    opc = 7'b0100011;
          2'd1:    opc = 7'b1100011;
          2'd2:    opc = 7'b1101111;
          default: opc = 7'b0110011;
        endcase
        return {a[31:7] ^ 25'h1ABCDEF, opc};
      end
    endcase
  endfunction

  assign imem_rdata = rom(imem_addr);

  function automatic logic [1:0] exp_imm(input logic [31:0] i);
    if (i[6:0] == 7'h23) return 2'b01;
    if (i[6:0] == 7'h63) return 2'b10;
    if (i[6:0] == 7'h6F) return 2'b11;
    return 2'b00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_bubble();
    m_instr = 32'h0000_0013;
    m_valid = 1'b0;
    m_bcnt  = m_bcnt + 1;
  endtask

  task automatic m_load(input logic [31:0] w, input logic [31:0] p);
    m_instr = w;
    m_pc_d  = p;
    m_pc4   = p + 4;
    m_valid = 1'b1;
    m_fcnt  = m_fcnt + 1;
  endtask

  // Advances the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic [31:0] tgt;
    tgt = {redirect_pc[31:2], 2'b00};
    if (reset) begin
      m_mode = 0; m_pc = 0; m_instr = 32'h13; m_pc_d = 0; m_pc4 = 0; m_valid = 0;
      m_fcnt = 0; m_bcnt = 0;
    end else if (m_mode == 0) begin
      if (redirect) m_pc = tgt;
      m_mode = 1;
    end else if (redirect) begin
      m_pc = tgt; m_bubble(); m_mode = 1;
    end else if (m_mode == 1) begin
      if (imem_ack && stall_d) begin
        m_hword = rom(m_pc); m_hpc = m_pc; m_pc = m_pc + 4; m_mode = 2;
      end else if (imem_ack) begin
        m_load(rom(m_pc), m_pc); m_pc = m_pc + 4;
      end else if (!stall_d) begin
        m_bubble();
      end
    end else if (!stall_d) begin
      m_load(m_hword, m_hpc); m_mode = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req", imem_req, (m_mode == 1));
      chk("imem_addr", imem_addr, m_pc);
      chk("instr_d", instr_d, m_instr);
      chk("pc_d", pc_d, m_pc_d);
      chk("pc_plus4_d", pc_plus4_d, m_pc4);
      chk("valid_d", valid_d, m_valid);
      chk("immsrc_d", immsrc_d, exp_imm(m_instr));
`ifdef FETCH_PERF_EN
      chk("fetch_cnt", fetch_cnt, m_fcnt);
      chk("bubble_cnt", bubble_cnt, m_bcnt);
`endif
    end
  end

  logic [1:0] imm_exp [4];

  initial begin
    imm_exp[0] = 2'b01; imm_exp[1] = 2'b10; imm_exp[2] = 2'b11; imm_exp[3] = 2'b00;
    m_fcnt = 0; m_bcnt = 0; m_mode = 0; m_pc = 0;
    reset = 1; imem_ack = 0; stall_d = 0; redirect = 0; redirect_pc = 0;
    tick(); tick();
    chk_en = 1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", valid_d, 0);
    chk("rst_instr", instr_d, 32'h0000_0013);
    chk("rst_pc_d", pc_d, 0);

    // Ack tied high: one BOOT cycle, then one instruction per edge
    reset = 0; imem_ack = 1;
    tick();
    chk("boot_done_req", imem_req, 1);
    chk("boot_done_addr", imem_addr, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("seq_pc_d", pc_d, i * 4);
      chk("seq_valid", valid_d, 1);
    end

    // Stall for three cycles with the word at 0x10 acked
    stall_d = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_req", imem_req, 0);
      chk("hold_pc_d", pc_d, 32'h0000_000C);
    end
    stall_d = 0;
    tick();
    chk("release_instr", instr_d, rom(32'h10));
    chk("release_pc_d", pc_d, 32'h10);
    chk("resume_addr", imem_addr, 32'h14);
    repeat (3) tick();
    chk("at_0x20", imem_addr, 32'h20);

    // Redirect with ack in the same cycle
    redirect = 1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 0;
    chk("redir_valid", valid_d, 0);
    chk("redir_instr", instr_d, 32'h0000_0013);
    chk("redir_addr", imem_addr, 32'h100);
    tick();
    chk("redir_pc_d", pc_d, 32'h100);

    // Redirect together with stall while holding
    stall_d = 1;
    tick();
    chk("hold2_req", imem_req, 0);
    redirect = 1; redirect_pc = 32'h0000_0300;
    tick();
    redirect = 0; stall_d = 0;
    chk("hold_redir_valid", valid_d, 0);
    chk("hold_redir_addr", imem_addr, 32'h300);
    chk("hold_redir_req", imem_req, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("immsrc_lit", immsrc_d, imm_exp[i]);
    end

    // PC wrap at the top of the address space
    redirect = 1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 0;
    tick(); tick();
    chk("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4_d, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    // Reset with an ack pending, then perf counter scenario
    reset = 1;
    tick();
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_valid", valid_d, 0);
    chk("mid_rst_pc_d", pc_d, 0);
    reset = 0;
    tick();
    repeat (5) tick();
    redirect = 1; redirect_pc = 32'h40;
    tick();
    redirect = 0;
`ifdef FETCH_PERF_EN
    chk("perf_fetch5", fetch_cnt, 5);
    chk("perf_bubble_ge1", (bubble_cnt >= 1), 1);
    reset = 1;
    tick();
    reset = 0;
    chk("perf_rst_f", fetch_cnt, 0);
    chk("perf_rst_b", bubble_cnt, 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      imem_ack    = ($urandom_range(0, 9) < 7);
      stall_d     = ($urandom_range(0, 9) < 3);
      redirect    = ($urandom_range(0, 99) < 8);
      redirect_pc = $urandom;
      reset       = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 0; redirect = 0; stall_d = 0;
    tick();
    chk_en = 0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
